uart_tx_ctl: RTL and testbench
==============================

// Module: uart_tx_ctl
// PURPOSE
//   UART transmit controller; the outbound counterpart of the UART receive path. Accepts bytes
//   over a valid/ready handshake into a one-deep holding register and serialises each one onto
//   TX_Pin_Out. Frame: start(0), 8 data bits LSB first, optional parity, STOP_BITS stop bits (1).
//   Bit timing comes from an internal bit-period counter, so no external BPS clock is needed.
// PARAMETERS
//   CLK_FREQ    50_000_000  input clock frequency, Hz
//   BAUD        9600        line rate; BPS_DIV = CLK_FREQ/BAUD (5208 at defaults), must be >= 2
//   PARITY_EN   0           1 = insert a parity bit after D7
//   PARITY_ODD  0           0 = even parity, 1 = odd parity (used only if PARITY_EN = 1)
//   STOP_BITS   1           number of stop bits; legal values 1 or 2
// PORTS
//   CLK          in   1  system clock; all logic is on the rising edge
//   RST          in   1  async active-high reset
//   TX_En_Sig    in   1  1 = frames may start; 0 = no new frame starts, current frame completes
//   TX_Data      in   8  byte to send; sampled when TX_Valid & TX_Ready
//   TX_Valid     in   1  producer has a byte
//   TX_Ready     out  1  holding register empty; a byte is accepted on an edge with Valid&Ready
//   TX_Pin_Out   out  1  serial line, registered, idles high
//   TX_Busy      out  1  high while a frame (start through last stop bit) is on the line
//   TX_Done_Sig  out  1  one-cycle pulse on the first cycle after the last stop bit
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-high.
//   Reset values: TX_Pin_Out=1, TX_Ready=1, TX_Busy=0, TX_Done_Sig=0.
//     Reset also sets FSM=IDLE, clears the holding register, and zeroes the bit counter.
//     Reset mid-frame aborts the frame; the line is high immediately.
//   Holding register: TX_Ready = ~hold_full (registered).
//     Accept edge: hold_full<=1 and TX_Data is latched.
//     The FSM load edge clears hold_full, so TX_Ready rises one cycle after the load.
//     Accept and load cannot coincide.
//   FSM states: IDLE -> START -> DATA(x8) -> [PARITY] -> STOP(xSTOP_BITS) -> IDLE or START.
//     IDLE: if hold_full & TX_En_Sig: load shifter, compute parity, go to START.
//     Each bit lasts exactly BPS_DIV cycles. The bit counter runs 0..BPS_DIV-1; the bit ends
//       when the count reaches BPS_DIV-1, then the counter wraps to 0.
//     DATA: TX_Pin_Out = shifter[0]; shift right at each bit end; a 3-bit index counts 0..7.
//     PARITY: bit = ^data for even, ~^data for odd.
//     STOP: line held 1. At the end of the last stop bit, pulse TX_Done_Sig.
//       If hold_full & TX_En_Sig: load and go straight to START (no idle gap between frames).
//       Otherwise go to IDLE.
//   Latency: accept at edge N -> load at edge N+1 -> TX_Pin_Out=0 from edge N+2.
//   TX_Busy is 1 from the edge that drives the start bit until the edge that returns to IDLE.
//   TX_En_Sig falling mid-frame: the frame completes normally. The buffered byte waits until
//     TX_En_Sig returns.
//   Holding-register contents are never overwritten while full (Ready=0 back-pressures).
// STRUCTURE
//   uart_pkg: state encoding localparams (IDLE/START/DATA/PARITY/STOP); BPS_DIV function;
//     frame-length constant. Shared with the receive path.
//   Sub-module uart_bps_gen: counter of width $clog2(BPS_DIV).
//     Input: run (clears and holds the count at 0 when low).
//     Output: bit_end pulse when count == BPS_DIV-1.
//   Top level: FSM, shifter, parity, holding register and outputs, in this file.
// TESTING  (sim override CLK_FREQ=160, BAUD=10 -> BPS_DIV=16)
//   1 Reset, then send 8'hA5 -> start bit from edge N+2; pin sequence 0,1,0,1,0,0,1,0,1,1.
//     Each bit is 16 cycles. TX_Done_Sig pulses 160 cycles after the start-bit edge.
//   2 Send 8'h55 then 8'h0F back-to-back, Valid held high.
//     -> 2nd byte accepted while the 1st is shifting.
//     -> Exactly 0 idle cycles between the 1st stop bit and the 2nd start bit.
//   3 PARITY_EN=1: even parity, 8'h07 -> parity bit 1; odd parity, 8'h07 -> parity bit 0.
//     With STOP_BITS=2 the line is high for 32 cycles after the parity bit.
//   4 TX_En_Sig=0 with a byte buffered -> the line stays high and TX_Ready stays 0.
//     Raise En -> start bit 1 cycle later.
//   5 Assert RST in the 4th data bit -> TX_Pin_Out=1 in the same cycle, TX_Ready=1, no Done.
//     After release, 8'h3C transmits correctly.
//   6 Valid held low for 1000 cycles -> line is constantly 1, Busy=0, Done never pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths: FSM state encoding,
// bit-period divider and frame-length helpers.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic int bps_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int frame_bits(input int parity_en, input int stop_bits);
        return 1 + DATA_BITS + parity_en + stop_bits;
    endfunction

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_bps_gen.sv
// Bit-period counter: counts 0..BPS_DIV-1 while run is high and flags the last cycle of each bit.
module uart_bps_gen #(
    parameter int BPS_DIV = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    output logic bit_end
);

    localparam int CNT_W = $clog2(BPS_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BPS_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (!run || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = run && (cnt == LAST);

endmodule

// File: rtl/uart_tx_ctl.sv
// UART transmit controller: one-deep holding register feeding a start/data/parity/stop serialiser.
// Line, busy and done outputs are registered one cycle behind the FSM state.
module uart_tx_ctl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TX_En_Sig,
    input  logic [7:0] TX_Data,
    input  logic       TX_Valid,
    output logic       TX_Ready,
    output logic       TX_Pin_Out,
    output logic       TX_Busy,
    output logic       TX_Done_Sig
);

    localparam int   BPS_DIV   = bps_div(CLK_FREQ, BAUD);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic ODD       = 1'(PARITY_ODD);

    uart_state_e state;
    logic [7:0]  hold_data;
    logic [7:0]  shifter;
    logic [2:0]  bit_idx;
    logic        stop_idx;
    logic        par_bit;
    logic        bit_end;
    logic        run;
    logic        hold_full;
    logic        last_stop_end;
    logic        load;
    logic        line_p0;
    logic        done_p0;

    assign hold_full     = ~TX_Ready;
    assign run           = (state != ST_IDLE);
    assign last_stop_end = (state == ST_STOP) && bit_end && (stop_idx == LAST_STOP);
    // A new frame may start from IDLE or directly off the end of the last stop bit.
    assign load          = hold_full && TX_En_Sig && ((state == ST_IDLE) || last_stop_end);

    uart_bps_gen #(.BPS_DIV(BPS_DIV)) u_bps (
        .CLK     (CLK),
        .RST     (RST),
        .run     (run),
        .bit_end (bit_end)
    );

    // Stage p0: line level implied by the current FSM state
    always_comb begin
        line_p0 = 1'b1;
        case (state)
            ST_START:  line_p0 = 1'b0;
            ST_DATA:   line_p0 = shifter[0];
            ST_PARITY: line_p0 = par_bit;
            default:   line_p0 = 1'b1;
        endcase
    end

    // Stage p0 -> p1: FSM, holding register and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            TX_Ready    <= 1'b1;
            hold_data   <= '0;
            shifter     <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            par_bit     <= 1'b0;
            done_p0     <= 1'b0;
            TX_Pin_Out  <= 1'b1;
            TX_Busy     <= 1'b0;
            TX_Done_Sig <= 1'b0;
        end else begin
            done_p0     <= 1'b0;
            TX_Pin_Out  <= line_p0;
            TX_Busy     <= run;
            TX_Done_Sig <= done_p0;

            case (state)
                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shifter <= {1'b0, shifter[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state    <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                            stop_idx <= 1'b0;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state    <= ST_STOP;
                        stop_idx <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (last_stop_end) begin
                        done_p0 <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (bit_end) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Load and accept are mutually exclusive: one needs the register full, the other empty.
            if (load) begin
                shifter  <= hold_data;
                par_bit  <= parity_bit(hold_data, ODD);
                bit_idx  <= '0;
                TX_Ready <= 1'b1;
                state    <= ST_START;
            end else if (TX_Valid && TX_Ready) begin
                TX_Ready  <= 1'b0;
                hold_data <= TX_Data;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_ctl.sv
// Bench for uart_tx_ctl: three parity/stop configurations driven in parallel and checked
// every cycle against a frame-timeline model, plus directed literal expectations.
module tb_uart_tx_ctl;

    localparam int BPS = 16;
    localparam int PEN [3] = '{0, 1, 1};
    localparam int POD [3] = '{0, 0, 1};
    localparam int NST [3] = '{1, 2, 1};

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic [2:0] rdy, pin, busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_ctl #(.CLK_FREQ(160), .BAUD(10), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .CLK(clk), .RST(rst), .TX_En_Sig(en), .TX_Data(data), .TX_Valid(valid),
        .TX_Ready(rdy[0]), .TX_Pin_Out(pin[0]), .TX_Busy(busy[0]), .TX_Done_Sig(done[0]));
    uart_tx_ctl #(.CLK_FREQ(160), .BAUD(10), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .CLK(clk), .RST(rst), .TX_En_Sig(en), .TX_Data(data), .TX_Valid(valid),
        .TX_Ready(rdy[1]), .TX_Pin_Out(pin[1]), .TX_Busy(busy[1]), .TX_Done_Sig(done[1]));
    uart_tx_ctl #(.CLK_FREQ(160), .BAUD(10), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .CLK(clk), .RST(rst), .TX_En_Sig(en), .TX_Data(data), .TX_Valid(valid),
        .TX_Ready(rdy[2]), .TX_Pin_Out(pin[2]), .TX_Busy(busy[2]), .TX_Done_Sig(done[2]));

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: each frame is a list of line levels; a frame loaded at edge L occupies the line
    // after edges L+1 .. L+nbits*BPS, and the next load may happen from that last edge onward.
    int          cyc = 0;
    bit          m_rdy  [3];
    bit          m_have [3];
    bit          m_b2b  [3];
    logic [7:0]  m_hold [3];
    logic [11:0] m_bits [3];
    int          m_L [3];
    int          m_F [3];
    int          m_done_at [3];

    function automatic void model_step(input int i);
        logic        ld, acc;
        logic [11:0] fr;
        int          nb;
        if (rst) begin
            m_rdy[i]     = 1'b1;
            m_have[i]    = 1'b0;
            m_b2b[i]     = 1'b0;
            m_F[i]       = cyc;
            m_done_at[i] = -1;
            return;
        end
        if (m_have[i] && cyc == m_F[i]) m_done_at[i] = cyc + 1;
        ld  = !m_rdy[i] && en && (cyc >= m_F[i]);
        acc = valid && m_rdy[i];
        if (ld) begin
            nb = 1 + 8 + PEN[i] + NST[i];
            fr = '1;
            fr[0] = 1'b0;
            for (int b = 0; b < 8; b++) fr[b+1] = m_hold[i][b];
            if (PEN[i] != 0) fr[9] = (^m_hold[i]) ^ (POD[i] != 0);
            m_bits[i] = fr;
            m_b2b[i]  = m_have[i] && (cyc == m_F[i]);
            m_L[i]    = cyc;
            m_F[i]    = cyc + nb * BPS;
            m_have[i] = 1'b1;
            m_rdy[i]  = 1'b1;
        end else if (acc) begin
            m_rdy[i]  = 1'b0;
            m_hold[i] = data;
        end
    endfunction

    function automatic logic in_frame(input int i);
        return m_have[i] && (cyc > m_L[i]) && (cyc <= m_F[i]);
    endfunction

    function automatic logic exp_pin(input int i);
        if (in_frame(i)) return m_bits[i][(cyc - m_L[i] - 1) / BPS];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("cyc%0d inst%0d pin", cyc, i), pin[i], exp_pin(i));
                chk($sformatf("cyc%0d inst%0d ready", cyc, i), rdy[i], m_rdy[i]);
                chk($sformatf("cyc%0d inst%0d busy", cyc, i), busy[i],
                    in_frame(i) || (m_b2b[i] && cyc == m_L[i]));
                chk($sformatf("cyc%0d inst%0d done", cyc, i), done[i], cyc == m_done_at[i]);
            end
        end
    end

    task automatic send_byte(input logic [7:0] d);
        @(negedge clk);
        valid = 1'b1;
        data  = d;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_low(input int i, output int c);
        c = 0;
        do begin
            @(posedge clk);
            #1;
            c++;
        end while (pin[i] !== 1'b0 && c < 60);
    endtask

    task automatic check_frame(input int i, input logic [11:0] expv, input int nb,
                               input int done_exp, input string tag);
        int c;
        int done_t;
        wait_low(i, c);
        chki({tag, " start latency"}, c, 2);
        done_t = -1;
        for (int t = 1; t <= nb * BPS + 10; t++) begin
            @(posedge clk);
            #1;
            if (t % BPS == BPS / 2 && t / BPS < nb)
                chk($sformatf("%s bit%0d", tag, t / BPS), pin[i], expv[t / BPS]);
            if (done[i] === 1'b1 && done_t < 0) done_t = t;
        end
        chki({tag, " done offset"}, done_t, done_exp);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        valid = 1'b0;
        en    = 1'b1;
        while ((busy !== 3'b000 || rdy !== 3'b111) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chki("drain to idle", int'(busy === 3'b000 && rdy === 3'b111), 1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int c, bad, lows, dones, hi, d1, d2;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset inst%0d pin", i), pin[i], 1'b1);
            chk($sformatf("reset inst%0d ready", i), rdy[i], 1'b1);
            chk($sformatf("reset inst%0d busy", i), busy[i], 1'b0);
            chk($sformatf("reset inst%0d done", i), done[i], 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Single byte: 0,1,0,1,0,0,1,0,1,1 on the line, done 160 cycles after the start edge
        send_byte(8'hA5);
        check_frame(0, 12'b0011_0100_1010, 10, 160, "t1 A5");

        // Back-to-back bytes with Valid held high
        wait_idle();
        @(negedge clk);
        valid = 1'b1;
        data  = 8'h55;
        @(posedge clk);
        @(negedge clk);
        data = 8'h0F;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t2 second byte accepted", rdy[0], 1'b0);
        chk("t2 first start bit", pin[0], 1'b0);
        @(negedge clk);
        valid = 1'b0;
        lows  = 0;
        dones = 0;
        for (int t = 1; t <= 330; t++) begin
            @(posedge clk);
            #1;
            if (t == 159) chk("t2 last stop bit", pin[0], 1'b1);
            if (t == 160) chk("t2 second start bit", pin[0], 1'b0);
            if (t <= 319 && busy[0] !== 1'b1) lows++;
            if (done[0] === 1'b1) dones++;
        end
        chki("t2 busy gap cycles", lows, 0);
        chki("t2 done pulses", dones, 2);

        // Parity: 0x07 has three ones
        wait_idle();
        send_byte(8'h07);
        wait_low(1, c);
        chki("t3 start latency", c, 2);
        hi = 0;
        d1 = -1;
        d2 = -1;
        for (int t = 1; t <= 200; t++) begin
            @(posedge clk);
            #1;
            if (t == 152) begin
                chk("t3 even parity bit", pin[1], 1'b1);
                chk("t3 odd parity bit", pin[2], 1'b0);
            end
            if (t >= 160 && t < 192 && pin[1] === 1'b1) hi++;
            if (done[1] === 1'b1 && d1 < 0) d1 = t;
            if (done[2] === 1'b1 && d2 < 0) d2 = t;
        end
        chki("t3 two stop bits high cycles", hi, 32);
        chki("t3 even/2stop done offset", d1, 192);
        chki("t3 odd/1stop done offset", d2, 176);

        // Disabled with a byte buffered
        wait_idle();
        @(negedge clk);
        en = 1'b0;
        send_byte(8'h96);
        bad = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (pin[0] !== 1'b1 || rdy[0] !== 1'b0) bad++;
        end
        chki("t4 held while disabled", bad, 0);
        @(negedge clk);
        en = 1'b1;
        wait_low(0, c);
        chki("t4 start after enable", c, 2);

        // Reset in the 4th data bit with a second byte buffered
        wait_idle();
        send_byte(8'hF0);
        wait_low(0, c);
        @(negedge clk);
        valid = 1'b1;
        data  = 8'hAA;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (71) @(posedge clk);
        #1;
        chk("t5 pre-reset D3", pin[0], 1'b0);
        chk("t5 pre-reset ready", rdy[0], 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5 reset pin", pin[0], 1'b1);
        chk("t5 reset ready", rdy[0], 1'b1);
        chk("t5 reset busy", busy[0], 1'b0);
        bad = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done[0] !== 1'b0) bad++;
        end
        chki("t5 no done during reset", bad, 0);
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h3C);
        check_frame(0, 12'b0010_0111_1000, 10, 160, "t5 3C");

        // Long idle
        wait_idle();
        bad = 0;
        repeat (1000) begin
            @(posedge clk);
            #1;
            if (pin[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) bad++;
        end
        chki("t6 idle line", bad, 0);

        // Random traffic with enable toggling
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (k % 64 == 0) en = ($urandom_range(3) != 0);
            valid = ($urandom_range(3) == 0);
            data  = 8'($urandom);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
